note_player: RTL and testbench

//  Consumes {note, duration, new_note} from song_reader. Holds the current note for its

---
 rtl/note_player.sv | 119 +++++++++++
 tb/tb_note_player.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// ============================================================================
//  note_player: holds each note for its beat count, pulses note_done at the
//  end, and converts the note index to a phase step. Revision: 1.0
// ============================================================================
`default_nettype none

module note_player #(
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6,
   parameter int STEP_WIDTH     = 20
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      play_enable,
   input  logic                      load_new_note,
   input  logic [NOTE_WIDTH-1:0]     note_to_load,
   input  logic [DURATION_WIDTH-1:0] duration_to_load,
   input  logic                      beat,
   output logic [STEP_WIDTH-1:0]     step_size,
   output logic                      note_active,
   output logic                      note_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [NOTE_WIDTH-1:0]     note_q, note_d;
   logic [DURATION_WIDTH-1:0] dur_cnt_q, dur_cnt_d;
   logic                      rom_valid_q, rom_valid_d;
   logic [STEP_WIDTH-1:0]     rom_dout_q, rom_dout_d;

   // Frequency table: top-octave steps (A5..G#6, 48 kHz, 20-bit phase),
   // lower octaves derived by right shift. Note 1 = A0, 49 = A4 (440 Hz).
   function automatic logic [STEP_WIDTH-1:0] rom_lookup(input logic [NOTE_WIDTH-1:0] n);
      logic [NOTE_WIDTH-1:0] idx;
      logic [NOTE_WIDTH-1:0] oct;
      logic [NOTE_WIDTH-1:0] semi;
      logic [STEP_WIDTH-1:0] base;
      idx  = n - NOTE_WIDTH'(1);
      oct  = idx / NOTE_WIDTH'(12);
      semi = idx % NOTE_WIDTH'(12);
      case (semi)
         NOTE_WIDTH'(0):  base = STEP_WIDTH'(19224);
         NOTE_WIDTH'(1):  base = STEP_WIDTH'(20367);
         NOTE_WIDTH'(2):  base = STEP_WIDTH'(21578);
         NOTE_WIDTH'(3):  base = STEP_WIDTH'(22861);
         NOTE_WIDTH'(4):  base = STEP_WIDTH'(24221);
         NOTE_WIDTH'(5):  base = STEP_WIDTH'(25661);
         NOTE_WIDTH'(6):  base = STEP_WIDTH'(27187);
         NOTE_WIDTH'(7):  base = STEP_WIDTH'(28803);
         NOTE_WIDTH'(8):  base = STEP_WIDTH'(30516);
         NOTE_WIDTH'(9):  base = STEP_WIDTH'(32331);
         NOTE_WIDTH'(10): base = STEP_WIDTH'(34253);
         default:         base = STEP_WIDTH'(36290);
      endcase
      if (n == '0) begin
         rom_lookup = '0;
      end else begin
         rom_lookup = base >> (NOTE_WIDTH'(5) - oct);
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      note_d      = note_q;
      dur_cnt_d   = dur_cnt_q;
      rom_valid_d = 1'b1;
      rom_dout_d  = rom_lookup(note_q);

      if (load_new_note) begin
         note_d      = note_to_load;
         dur_cnt_d   = duration_to_load;
         rom_valid_d = 1'b0;
         state_d     = (duration_to_load != '0) ? PLAYING : DONE;
      end else begin
         case (state_q)
            PLAYING: begin
               // Beats arriving while paused are dropped, not queued.
               if (beat && play_enable && (dur_cnt_q != '0)) begin
                  dur_cnt_d = dur_cnt_q - 1'b1;
                  if (dur_cnt_q == DURATION_WIDTH'(1)) begin
                     state_d = DONE;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         note_q      <= '0;
         dur_cnt_q   <= '0;
         rom_valid_q <= 1'b0;
         rom_dout_q  <= '0;
      end else begin
         state_q     <= state_d;
         note_q      <= note_d;
         dur_cnt_q   <= dur_cnt_d;
         rom_valid_q <= rom_valid_d;
         rom_dout_q  <= rom_dout_d;
      end
   end

   assign note_active = (state_q == PLAYING);
   assign note_done   = (state_q == DONE);
   assign step_size   = (note_active && play_enable && rom_valid_q && (note_q != '0))
                        ? rom_dout_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_note_player.sv
// ============================================================================
//  tb_note_player: directed scenarios plus random traffic for note_player,
//  checked against a beat-counting reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_note_player;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        play_enable = 1'b0;
   logic        load_new_note = 1'b0;
   logic [5:0]  note_to_load = '0;
   logic [5:0]  duration_to_load = '0;
   logic        beat = 1'b0;
   logic [19:0] step_size;
   logic        note_active;
   logic        note_done;

   int total = 0;
   int bad   = 0;

   note_player dut (
      .clk              (clk),
      .reset            (reset),
      .play_enable      (play_enable),
      .load_new_note    (load_new_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .beat             (beat),
      .step_size        (step_size),
      .note_active      (note_active),
      .note_done        (note_done)
   );

   always #5 clk = ~clk;

   // Reference: equal-tempered table, top octave A5..G#6 at 48 kHz / 2^20.
   int base_tab [12] = '{19224, 20367, 21578, 22861, 24221, 25661,
                         27187, 28803, 30516, 32331, 34253, 36290};

   function automatic logic [19:0] ref_step(input int n);
      int idx;
      if (n == 0) return 20'd0;
      idx = n - 1;
      return 20'(base_tab[idx % 12] >> (5 - idx / 12));
   endfunction

   // Model: is a note sounding, beats remaining, cycles since last load.
   logic m_playing, m_done;
   int   m_left, m_age, m_note;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_playing <= 1'b0;
         m_done    <= 1'b0;
         m_left    <= 0;
         m_age     <= 0;
         m_note    <= 0;
      end else if (load_new_note) begin
         m_note    <= int'(note_to_load);
         m_left    <= int'(duration_to_load);
         m_age     <= 0;
         m_playing <= (duration_to_load != 0);
         m_done    <= (duration_to_load == 0);
      end else begin
         m_age     <= (m_age < 5) ? m_age + 1 : m_age;
         m_done    <= m_playing && beat && play_enable && (m_left == 1);
         m_playing <= m_playing && !(beat && play_enable && (m_left == 1));
         if (m_playing && beat && play_enable) m_left <= m_left - 1;
      end
   end

   function automatic logic [21:0] exp_vec();
      logic [19:0] s;
      s = (m_playing && play_enable && (m_age >= 1)) ? ref_step(m_note) : 20'd0;
      return {m_playing, m_done, s};
   endfunction

   task automatic drive(input logic l, input logic [5:0] n, input logic [5:0] d, input logic b);
      load_new_note    = l;
      note_to_load     = n;
      duration_to_load = d;
      beat             = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({note_active, note_done, step_size} !== 22'd0) begin
         bad++;
         $display("FAIL reset_hold got=%h exp=0", {note_active, note_done, step_size});
      end
      @(negedge clk);
      reset = 1'b1;
      play_enable = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 6'd0, 6'd0, 1'b1);
         total++;
         if ({note_active, note_done, step_size} !== 22'd0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=0", c, {note_active, note_done, step_size});
         end
      end
   endtask

   task automatic test_basic();
      int dones = 0;
      play_enable = 1'b1;
      drive(1'b1, 6'd37, 6'd4, 1'b0);
      for (int c = 0; c < 40; c++) begin
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL basic cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
         if (c == 1) begin
            total++;
            if (step_size !== 20'd4806) begin
               bad++;
               $display("FAIL basic_rom37 got=%0d exp=4806", step_size);
            end
         end
         if (note_done) dones++;
         drive(1'b0, 6'd0, 6'd0, (c % 8) == 7);
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL basic_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_pause();
      int dones = 0;
      logic [5:0] n;
      n = 6'($urandom_range(1, 63));
      play_enable = 1'b1;
      drive(1'b1, n, 6'd4, 1'b0);
      for (int c = 0; c < 100; c++) begin
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL pause cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
         if (note_done) dones++;
         play_enable = !(c >= 19 && c < 59);
         drive(1'b0, 6'd0, 6'd0, (c % 8) == 7);
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL pause_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_rest();
      play_enable = 1'b1;
      drive(1'b1, 6'd0, 6'd2, 1'b0);
      for (int c = 0; c < 24; c++) begin
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL rest cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
         drive(1'b0, 6'd0, 6'd0, (c % 6) == 5);
      end
   endtask

   task automatic test_zero_dur();
      play_enable = 1'b1;
      drive(1'b1, 6'd10, 6'd0, 1'b0);
      total++;
      if ({note_active, note_done, step_size} !== {1'b0, 1'b1, 20'd0}) begin
         bad++;
         $display("FAIL zero_dur got=%h exp=%h", {note_active, note_done, step_size}, {1'b0, 1'b1, 20'd0});
      end
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 6'd0, 6'd0, 1'b1);
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL zero_dur_after cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      int  dones = 0;
      bit  second = 0;
      play_enable = 1'b1;
      drive(1'b1, 6'd5, 6'd3, 1'b1);
      for (int c = 0; c < 60; c++) begin
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
         if (note_done) dones++;
         if (note_done && !second) begin
            second = 1;
            drive(1'b1, 6'($urandom_range(1, 63)), 6'd2, 1'b0);
            total++;
            if (note_active !== 1'b1) begin
               bad++;
               $display("FAIL b2b_reload_active got=%b exp=1", note_active);
            end
         end else begin
            drive(1'b0, 6'd0, 6'd0, (c % 6) == 5);
         end
      end
      total++;
      if (dones != 2 || !second) begin
         bad++;
         $display("FAIL b2b_done_count got=%0d exp=2", dones);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      play_enable = 1'b1;
      drive(1'b1, 6'($urandom_range(1, 63)), 6'd5, 1'b0);
      while (m_left != 3 && guard < 50) begin
         drive(1'b0, 6'd0, 6'd0, (guard % 4) == 3);
         guard++;
      end
      total++;
      if (m_left != 3 || note_active !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_setup got=%b exp=1", note_active);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({note_active, note_done, step_size} !== 22'd0) begin
         bad++;
         $display("FAIL reset_mid_async got=%h exp=0", {note_active, note_done, step_size});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 6'd0, 6'd0, 1'($urandom_range(0, 1)));
         total++;
         if ({note_active, note_done, step_size} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid_idle cyc=%0d got=%h exp=0", c, {note_active, note_done, step_size});
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         play_enable = ($urandom_range(0, 7) != 0);
         drive(($urandom_range(0, 19) == 0), 6'($urandom_range(0, 63)),
               6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
         total++;
         if ({note_active, note_done, step_size} !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", c, {note_active, note_done, step_size}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_rest();
      test_zero_dur();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
